bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits, 1..8.
REQ-002 SHALL have parameter AUTO_RELOAD, default 0: 1 = periodic reload at zero, 0 = one-shot.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port load  input  1  load strobe; captures load_val.
REQ-006 SHALL have port load_val  input  4*DIGITS  BCD preset; digit 0 is in bits [3:0].
REQ-007 SHALL have port start  input  1  start/resume strobe.
REQ-008 SHALL have port stop  input  1  pause strobe.
REQ-009 SHALL have port tick  input  1  count-enable strobe; one decrement per cycle tick=1 in RUN.
REQ-010 SHALL have port out  output  4*DIGITS  current BCD count, registered.
REQ-011 SHALL have port busy  output  1  1 while in RUN.
REQ-012 SHALL have port zero  output  1  1 when out equals all-zero digits.
REQ-013 SHALL have port done  output  1  registered one-cycle expiry pulse.

Function
REQ-014 SHALL implement states IDLE, RUN, EXPIRED.
REQ-015 SHALL hold a reload register of 4*DIGITS bits, written only by load.
REQ-016 SHALL apply input priority per cycle: rst > load > stop > start > tick.
REQ-017 On load in any state, SHALL write out and reload with load_val, clamping any digit >9 to 9; go to IDLE; done=0 that cycle.
REQ-018 On stop in RUN, SHALL go to IDLE with out held; stop in IDLE or EXPIRED is ignored.
REQ-019 On start in IDLE with out≠0, SHALL go to RUN.
REQ-020 On start in IDLE with out=0: AUTO_RELOAD=0 goes to EXPIRED with done=1 next cycle; AUTO_RELOAD=1 goes to RUN.
REQ-021 On start in EXPIRED, SHALL copy reload to out, then apply REQ-019/REQ-020 to the reloaded value on the same edge.
REQ-022 start in RUN SHALL be ignored.
REQ-023 In RUN, on tick, SHALL decrement out as BCD: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit; no binary wrap.
REQ-024 AUTO_RELOAD=0: a tick at out=1 SHALL produce out=0, state EXPIRED and done=1 on the same edge.
REQ-025 AUTO_RELOAD=1: a tick at out=1 SHALL produce out=0 and stay in RUN.
REQ-026 AUTO_RELOAD=1: a tick at out=0 in RUN SHALL load out from reload and pulse done; the period is reload+1 ticks.
REQ-027 AUTO_RELOAD=1 with reload=0 SHALL pulse done on every tick.
REQ-028 tick SHALL be ignored in IDLE and EXPIRED.
REQ-029 done SHALL be high for exactly one cycle per expiry event, including back-to-back ticks.
REQ-030 busy SHALL be 1 exactly when state=RUN, registered with the state.
REQ-031 zero SHALL be decoded combinationally from the out register.
REQ-032 out SHALL never hold a digit >9.

Reset
REQ-033 On a rising clk edge with rst=1, SHALL set: out=0, reload=0, state=IDLE, done=0, busy=0; zero then reads 1.
REQ-034 rst SHALL override load, start, stop and tick in the same cycle, including mid-count in RUN.
REQ-035 With rst=0, no output SHALL change except on a clk rising edge.

Verification
REQ-036 Scenario: DIGITS=4, AUTO_RELOAD=0; load 0x0012, start, 12 consecutive ticks -> out steps 0012, 0011, 0010, 0009 … 0000; done=1 for one cycle at 0000; state EXPIRED; busy=0.
REQ-037 Scenario: load 0x1000, start, 1 tick -> out=0999; load 0x0A5F -> out=0959 (clamped), state IDLE.
REQ-038 Scenario: AUTO_RELOAD=1; load 0x0002, start, 9 ticks -> out 0001, 0000, 0002, …; done pulses on ticks 3, 6 and 9.
REQ-039 Scenario: in RUN at 0005, assert stop, start and tick in the same cycle -> IDLE, out=0005; then 3 ticks -> out stays 0005.
REQ-040 Scenario: in RUN at 0003, assert rst and tick in the same cycle -> out=0000, IDLE, done=0, zero=1; load and start then still work.
REQ-041 Scenario: AUTO_RELOAD=0; load 0x0000, start -> EXPIRED with a single done pulse; a second start gives a single done pulse again.

Source files
------------

// File: rtl/bcd_down_timer_if.sv
// Control/data bundle for bcd_down_timer: strobes and preset in, BCD count and status out.
interface bcd_down_timer_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  stop;
    logic                  tick;
    logic [4*DIGITS-1:0]   out;
    logic                  busy;
    logic                  zero;
    logic                  done;

    modport master (
        output load, load_val, start, stop, tick,
        input  out, busy, zero, done
    );

    modport slave (
        input  load, load_val, start, stop, tick,
        output out, busy, zero, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter with one-shot or periodic expiry and a one-cycle done pulse.
//
// state   | meaning
// IDLE    | loaded or paused; ticks ignored
// RUN     | counting down on tick
// EXPIRED | one-shot reached zero; start reloads from the reload register
module bcd_down_timer #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic clk,
    input  logic rst,
    bcd_down_timer_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   out_q;
    logic [W-1:0]   reload_q;
    logic           done_q;

    logic [W-1:0]   clamp_d;
    logic [W-1:0]   dec_d;
    logic           out_zero;
    logic           out_one;
    logic           reload_zero;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple borrow: digits at 0 become 9 until the first nonzero digit absorbs it.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        clamp_d     = bcd_clamp(bus.load_val);
        dec_d       = bcd_dec(out_q);
        out_zero    = (out_q == '0);
        out_one     = (out_q == W'(1));
        reload_zero = (reload_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            reload_q <= '0;
            state_q  <= IDLE;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                out_q    <= clamp_d;
                reload_q <= clamp_d;
                state_q  <= IDLE;
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.stop) begin
                            state_q <= IDLE;
                        end else if (bus.tick) begin
                            if (out_zero) begin
                                done_q <= 1'b1;
                                if (AUTO_RELOAD) out_q   <= reload_q;
                                else             state_q <= EXPIRED;
                            end else begin
                                out_q <= dec_d;
                                if (out_one && !AUTO_RELOAD) begin
                                    state_q <= EXPIRED;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    IDLE: begin
                        if (bus.start) begin
                            if (!out_zero || AUTO_RELOAD) begin
                                state_q <= RUN;
                            end else begin
                                state_q <= EXPIRED;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    EXPIRED: begin
                        if (bus.start) begin
                            out_q <= reload_q;
                            if (!reload_zero || AUTO_RELOAD) begin
                                state_q <= RUN;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q == RUN);
    assign bus.zero = out_zero;
    assign bus.done = done_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench: vector tables for a one-shot and a periodic instance, expectations via scoreboard queue.
module tb_bcd_down_timer;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    bcd_down_timer_if #(.DIGITS(4)) if0 ();
    bcd_down_timer_if #(.DIGITS(4)) if1 ();

    bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u0 (.clk(clk), .rst(rst0), .bus(if0.slave));
    bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] val;
        logic        start;
        logic        stop;
        logic        tick;
        logic [15:0] e_out;
        logic        e_busy;
        logic        e_zero;
        logic        e_done;
    } vec_t;

    vec_t  tbl[$];
    vec_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string scn;

    function automatic vec_t mk(input logic r, input logic ld, input logic [15:0] v,
                                input logic st, input logic sp, input logic tk,
                                input logic [15:0] eo, input logic eb, input logic ed);
        vec_t x;
        x.rst = r; x.load = ld; x.val = v; x.start = st; x.stop = sp; x.tick = tk;
        x.e_out = eo; x.e_busy = eb; x.e_zero = (eo == 16'h0000); x.e_done = ed;
        return x;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    task automatic chk(input string what, input int idx, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s[%0d] %s: got %h want %h", scn, idx, what, got, want);
    endtask

    task automatic run_tbl(input int sel);
        vec_t v, e;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (sel == 0) begin
                rst0 = v.rst; if0.load = v.load; if0.load_val = v.val;
                if0.start = v.start; if0.stop = v.stop; if0.tick = v.tick;
            end else begin
                rst1 = v.rst; if1.load = v.load; if1.load_val = v.val;
                if1.start = v.start; if1.stop = v.stop; if1.tick = v.tick;
            end
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (sel == 0) begin
                chk("out",  i, if0.out,          e.e_out);
                chk("busy", i, {15'd0, if0.busy}, {15'd0, e.e_busy});
                chk("zero", i, {15'd0, if0.zero}, {15'd0, e.e_zero});
                chk("done", i, {15'd0, if0.done}, {15'd0, e.e_done});
            end else begin
                chk("out",  i, if1.out,          e.e_out);
                chk("busy", i, {15'd0, if1.busy}, {15'd0, e.e_busy});
                chk("zero", i, {15'd0, if1.zero}, {15'd0, e.e_zero});
                chk("done", i, {15'd0, if1.done}, {15'd0, e.e_done});
            end
        end
        tbl.delete();
    endtask

    initial begin
        int cnt;
        logic d;
        rst0 = 1'b0; rst1 = 1'b0;
        if0.load = 0; if0.load_val = 0; if0.start = 0; if0.stop = 0; if0.tick = 0;
        if1.load = 0; if1.load_val = 0; if1.start = 0; if1.stop = 0; if1.tick = 0;
        @(posedge clk); #1;

        // one-shot count from 12 to expiry
        scn = "oneshot12";
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0012, 0, 0, 0, 16'h0012, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0012, 1, 0));
        for (int k = 1; k <= 12; k++)
            tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, to_bcd(12 - k), (k != 12), (k == 12)));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
        run_tbl(0);

        scn = "borrow_clamp";
        tbl.push_back(mk(0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0999, 1, 0));
        tbl.push_back(mk(0, 1, 16'h0A5F, 0, 0, 0, 16'h0959, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0959, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0959, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0958, 1, 0));
        run_tbl(0);

        scn = "stop_prio";
        tbl.push_back(mk(0, 1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0005, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 16'h0005, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0005, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0005, 0, 0));
        run_tbl(0);

        scn = "rst_midrun";
        tbl.push_back(mk(0, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0007, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1));
        // start from EXPIRED reloads the preset and resumes counting
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0));
        run_tbl(0);

        scn = "zero_start";
        tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        run_tbl(0);

        // periodic instance: integer model of reload+1 period
        scn = "auto2";
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0));
        cnt = 2;
        for (int k = 1; k <= 9; k++) begin
            if (cnt == 0) begin cnt = 2; d = 1'b1; end
            else begin cnt = cnt - 1; d = 1'b0; end
            tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, to_bcd(cnt), 1, d));
        end
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0002, 0, 0));
        run_tbl(1);

        scn = "auto0";
        tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0));
        run_tbl(1);

        scn = "auto_clamp_all";
        tbl.push_back(mk(0, 1, 16'hFFFF, 0, 0, 0, 16'h9999, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h9999, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h9998, 1, 0));
        tbl.push_back(mk(0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0100, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0099, 1, 0));
        run_tbl(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
